branch_regfile_unit: RTL and testbench

Decode-stage datapath block for the RV32I pipeline. It combines the 32x32 integer register file (two combinational read ports, one clocked write-back port) with the branch/jump resolution unit. The branch unit consumes the register-file read values and the decoded immediate fields, and produces the taken flag and target PC for the fetch stage.

---
 rtl/branch_regfile_unit.sv | 141 ++++++++++++++
 tb/tb_branch_regfile_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_regfile_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_regfile_unit
// Description : RV32I decode-stage register file (2R/1W, write-first bypass)
//               combined with the branch/jump resolution unit.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_regfile_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [4:0]      i_reg_num_1,
    input  logic [4:0]      i_reg_num_2,
    input  logic [4:0]      i_w_reg_num,
    input  logic [XLEN-1:0] i_w_val,
    input  logic            i_op,
    input  logic [XLEN-1:0] i_pc,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_func_3,
    input  logic [6:0]      i_func_7,
    input  logic [11:0]     i_imm_12_i,
    input  logic [19:0]     i_imm_20,
    input  logic [11:0]     i_imm_12_b,
    output logic [XLEN-1:0] rs_1,
    output logic [XLEN-1:0] rs_2,
    output logic            b_taken,
    output logic [XLEN-1:0] b_pc
);

    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    // ------------------------------------------------------------------
    // Register file storage; x0 is a hard-wired zero, never stored.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_regs [NREGS];
    logic            w_wr_en;

    assign w_wr_en = i_op && (i_w_reg_num != 5'd0);
    assign w_regs[0] = '0;

    generate
        for (genvar g = 1; g < NREGS; g++) begin : g_regs
            logic [XLEN-1:0] r_q;
            logic [XLEN-1:0] r_d;

            assign r_d = (w_wr_en && (i_w_reg_num == 5'(g))) ? i_w_val : r_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_q <= '0;
                end else begin
                    r_q <= r_d;
                end
            end

            assign w_regs[g] = r_q;
        end
    endgenerate

    // Same-cycle write-back wins over the stored value; gated off in reset
    // so that reads during reset are zero regardless of the write port.
    logic w_byp_1;
    logic w_byp_2;

    assign w_byp_1 = i_rst_n && w_wr_en && (i_w_reg_num == i_reg_num_1);
    assign w_byp_2 = i_rst_n && w_wr_en && (i_w_reg_num == i_reg_num_2);

    assign rs_1 = w_byp_1 ? i_w_val : w_regs[i_reg_num_1];
    assign rs_2 = w_byp_2 ? i_w_val : w_regs[i_reg_num_2];

    // ------------------------------------------------------------------
    // Branch / jump resolution
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_jalr_sum;
    logic            w_cond;

    assign w_imm_j     = {{(XLEN-21){i_imm_20[19]}}, i_imm_20, 1'b0};
    assign w_imm_b     = {{(XLEN-13){i_imm_12_b[11]}}, i_imm_12_b, 1'b0};
    assign w_imm_i     = {{(XLEN-12){i_imm_12_i[11]}}, i_imm_12_i};
    assign w_pc_plus4  = i_pc + XLEN'(4);
    assign w_br_target = i_pc + w_imm_b;
    assign w_jalr_sum  = rs_1 + w_imm_i;

    always_comb begin
        w_cond = 1'b0;
        case (i_func_3)
            c_F3_BEQ:  w_cond = (rs_1 == rs_2);
            c_F3_BNE:  w_cond = (rs_1 != rs_2);
            c_F3_BLT:  w_cond = ($signed(rs_1) <  $signed(rs_2));
            c_F3_BGE:  w_cond = ($signed(rs_1) >= $signed(rs_2));
            c_F3_BLTU: w_cond = (rs_1 <  rs_2);
            c_F3_BGEU: w_cond = (rs_1 >= rs_2);
            default:   w_cond = 1'b0;
        endcase
    end

    always_comb begin
        b_taken = 1'b0;
        b_pc    = w_pc_plus4;
        case (i_opcode)
            c_OP_JAL: begin
                b_taken = 1'b1;
                b_pc    = i_pc + w_imm_j;
            end
            c_OP_JALR: begin
                b_taken = 1'b1;
                b_pc    = {w_jalr_sum[XLEN-1:1], 1'b0};
            end
            c_OP_BRANCH: begin
                b_taken = w_cond;
                b_pc    = w_cond ? w_br_target : w_pc_plus4;
            end
            default: begin
                b_taken = 1'b0;
                b_pc    = w_pc_plus4;
            end
        endcase
    end

    // func7 is part of the decode bundle but carries no meaning here.
    logic w_unused;
    assign w_unused = ^i_func_7;

endmodule
`default_nettype wire

// File: tb/tb_branch_regfile_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_regfile_unit
// Description : Directed self-checking bench for branch_regfile_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_regfile_unit;

    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_ADDI   = 7'b0010011;
    localparam logic [6:0] c_RTYPE  = 7'b0110011;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [4:0]  i_reg_num_1, i_reg_num_2, i_w_reg_num;
    logic [31:0] i_w_val, i_pc;
    logic        i_op;
    logic [6:0]  i_opcode, i_func_7;
    logic [2:0]  i_func_3;
    logic [11:0] i_imm_12_i, i_imm_12_b;
    logic [19:0] i_imm_20;
    logic [31:0] rs_1, rs_2, b_pc;
    logic        b_taken;

    int r_checks = 0;
    int r_passed = 0;

    branch_regfile_unit dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_reg_num_1 (i_reg_num_1),
        .i_reg_num_2 (i_reg_num_2),
        .i_w_reg_num (i_w_reg_num),
        .i_w_val     (i_w_val),
        .i_op        (i_op),
        .i_pc        (i_pc),
        .i_opcode    (i_opcode),
        .i_func_3    (i_func_3),
        .i_func_7    (i_func_7),
        .i_imm_12_i  (i_imm_12_i),
        .i_imm_20    (i_imm_20),
        .i_imm_12_b  (i_imm_12_b),
        .rs_1        (rs_1),
        .rs_2        (rs_2),
        .b_taken     (b_taken),
        .b_pc        (b_pc)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got === exp) begin
            r_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        @(negedge i_clk);
        i_op        = 1'b1;
        i_w_reg_num = idx;
        i_w_val     = val;
        @(posedge i_clk);
        #1;
        i_op        = 1'b0;
    endtask

    task automatic branch(input logic [2:0] f3, input logic exp_t, input logic [31:0] exp_pc,
                          input string tag);
        @(negedge i_clk);
        i_opcode = c_BRANCH;
        i_func_3 = f3;
        #1;
        check_eq({tag, "_taken"}, {31'd0, b_taken}, {31'd0, exp_t});
        check_eq({tag, "_pc"}, b_pc, exp_pc);
    endtask

    initial begin
        i_rst_n = 1'b0; i_op = 1'b0;
        i_reg_num_1 = '0; i_reg_num_2 = '0; i_w_reg_num = '0; i_w_val = '0;
        i_pc = '0; i_opcode = c_ADDI; i_func_3 = '0; i_func_7 = '0;
        i_imm_12_i = '0; i_imm_20 = '0; i_imm_12_b = '0;

        // Reset: bypass must be inactive as well
        repeat (2) @(negedge i_clk);
        i_op = 1'b1; i_w_reg_num = 5'd3; i_w_val = 32'h1111_2222; i_reg_num_1 = 5'd3;
        #1;
        check_eq("rst_bypass_off", rs_1, 32'h0);
        i_op = 1'b0; i_reg_num_1 = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            @(negedge i_clk);
            i_reg_num_1 = 5'(i);
            i_reg_num_2 = 5'(31 - i);
            #1;
            check_eq($sformatf("rst_rd1_x%0d", i), rs_1, 32'h0);
            check_eq($sformatf("rst_rd2_x%0d", 31 - i), rs_2, 32'h0);
        end

        // x0 ignores writes, including the bypass path
        @(negedge i_clk);
        i_reg_num_1 = 5'd0;
        i_op = 1'b1; i_w_reg_num = 5'd0; i_w_val = 32'hDEAD_BEEF;
        #1;
        check_eq("x0_bypass", rs_1, 32'h0);
        @(posedge i_clk); #1; i_op = 1'b0;
        check_eq("x0_after_wr", rs_1, 32'h0);

        // Write then read, then asynchronous reset mid-cycle
        write_reg(5'd5, 32'h1234_5678);
        i_reg_num_1 = 5'd5; i_reg_num_2 = 5'd5;
        #1;
        check_eq("x5_rd1", rs_1, 32'h1234_5678);
        check_eq("x5_rd2", rs_2, 32'h1234_5678);
        @(negedge i_clk); #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("x5_async_rst", rs_1, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Same-cycle bypass, then stored value
        @(negedge i_clk);
        i_op = 1'b1; i_w_reg_num = 5'd7; i_w_val = 32'hA5A5_A5A5;
        i_reg_num_1 = 5'd7; i_reg_num_2 = 5'd0;
        #1;
        check_eq("byp_rd1", rs_1, 32'hA5A5_A5A5);
        check_eq("byp_rd2_other", rs_2, 32'h0);
        @(posedge i_clk); #1; i_op = 1'b0;
        check_eq("x7_stored", rs_1, 32'hA5A5_A5A5);

        // Branch signedness: x1 = -1, x2 = 1
        write_reg(5'd1, 32'hFFFF_FFFF);
        write_reg(5'd2, 32'h0000_0001);
        i_reg_num_1 = 5'd1; i_reg_num_2 = 5'd2;
        i_pc = 32'h100; i_imm_12_b = 12'h008;
        branch(3'b100, 1'b1, 32'h110, "blt");
        branch(3'b110, 1'b0, 32'h104, "bltu");
        branch(3'b000, 1'b0, 32'h104, "beq");
        branch(3'b111, 1'b1, 32'h110, "bgeu");
        branch(3'b001, 1'b1, 32'h110, "bne");
        branch(3'b101, 1'b0, 32'h104, "bge");
        branch(3'b010, 1'b0, 32'h104, "f3_010");
        branch(3'b011, 1'b0, 32'h104, "f3_011");

        // Backward branch target: imm_b = -8 -> offset -16
        i_imm_12_b = 12'hFF8;
        branch(3'b100, 1'b1, 32'h0F0, "blt_back");

        // Branch sees same-cycle write-back (x3 := 1, compare with x2)
        @(negedge i_clk);
        i_op = 1'b1; i_w_reg_num = 5'd3; i_w_val = 32'h1;
        i_reg_num_1 = 5'd3; i_imm_12_b = 12'h008;
        branch(3'b000, 1'b1, 32'h110, "beq_bypass");
        i_op = 1'b0; i_w_reg_num = 5'd0;

        // JAL backward
        @(negedge i_clk);
        i_opcode = c_JAL; i_pc = 32'h200; i_imm_20 = 20'hFFFF8;
        #1;
        check_eq("jal_taken", {31'd0, b_taken}, 32'd1);
        check_eq("jal_pc", b_pc, 32'h1F0);

        // JALR with bit-0 clear
        write_reg(5'd4, 32'h0000_1001);
        @(negedge i_clk);
        i_opcode = c_JALR; i_reg_num_1 = 5'd4; i_imm_12_i = 12'h003;
        #1;
        check_eq("jalr_taken", {31'd0, b_taken}, 32'd1);
        check_eq("jalr_pc", b_pc, 32'h1004);
        i_imm_12_i = 12'h000;
        #1;
        check_eq("jalr_lsb_clr", b_pc, 32'h1000);
        i_imm_12_i = 12'hFFF;
        #1;
        check_eq("jalr_neg", b_pc, 32'h1000);

        // Non-control-transfer opcodes
        @(negedge i_clk);
        i_opcode = c_ADDI; i_pc = 32'h300;
        #1;
        check_eq("addi_taken", {31'd0, b_taken}, 32'd0);
        check_eq("addi_pc", b_pc, 32'h304);
        i_opcode = c_RTYPE; i_pc = 32'hFFFF_FFFC;
        #1;
        check_eq("wrap_taken", {31'd0, b_taken}, 32'd0);
        check_eq("wrap_pc", b_pc, 32'h0);

        $display("%0d/%0d checks passed", r_passed, r_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
